// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read side: default widths,
// skid-buffer depth derivation and the data word type.
package fifo_pkg;

  localparam int FIFO_DW = 16;
  localparam int FIFO_AW = 4;

  typedef logic [FIFO_DW-1:0] word_t;

  // One slot per in-flight read plus one for the word being presented.
  function automatic int depth_of(input int rd_lat);
    return rd_lat + 1;
  endfunction

  // Pointer width. It never drops below 1 bit, even for a single-entry buffer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// DEPTH-entry circular buffer with push/pop and an occupancy count.
// Pointers wrap by compare-and-clear, so DEPTH need not be a power of two.
// Callers must not push when full and must not pop when empty.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_occ
);

  localparam int PW = ptr_w(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  // Storage is sized to the pointer range so indexing is width-exact.
  // Entries at or above DEPTH are never addressed.
  logic [DW-1:0] r_mem [2**PW];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [OW-1:0] r_occ;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Data storage: written on push only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy. A push and a pop in the same cycle leave occ unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      r_occ <= r_occ + OW'(i_push) - OW'(i_pop);
    end
  end

  assign o_data = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the async FIFO. It pops words while there is room,
// lands them RD_LAT cycles later in a skid buffer, and presents them downstream
// as a valid/ready stream.
// When FIFO_RD_STATS_EN is defined, the saturating counters pop_cnt and stall_cnt are added.
module fifo_stream_reader #(
  parameter int DW     = fifo_pkg::FIFO_DW,
  parameter int RD_LAT = 1,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          rempty,
  output logic          rinc,
  input  logic [DW-1:0] rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          idle
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CW-1:0] pop_cnt,
  output logic [CW-1:0] stall_cnt
`endif
);

  import fifo_pkg::*;

  localparam int DEPTH = depth_of(RD_LAT);
  localparam int OW    = $clog2(DEPTH+1);
  localparam int SW    = OW + 1;

  if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_lat
    $error("RD_LAT must be in 0..3");
  end
  if (CW < 1) begin : g_bad_cw
    $error("CW must be at least 1");
  end

  logic [OW-1:0] w_occ;
  logic [SW-1:0] w_infl_cnt;
  logic          w_cap;
  logic          w_pop;
  logic          w_room;

  assign m_valid = (w_occ != '0);
  assign w_pop   = m_valid & m_ready;
  // Count the slot freed by this cycle's pop. This lets a full buffer keep streaming.
  assign w_room  = (SW'(w_infl_cnt) + SW'(w_occ) - SW'(w_pop)) < SW'(DEPTH);
  assign rinc    = en & ~rempty & ~rst & w_room;
  assign idle    = (w_infl_cnt == '0) & (w_occ == '0);

  if (RD_LAT > 0) begin : g_infl
    logic [RD_LAT-1:0] r_infl_v;

    // rinc history. The oldest bit marks the cycle in which rdata is valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_infl_v <= '0;
      end else begin
        r_infl_v[0] <= rinc;
        for (int i = 1; i < RD_LAT; i++) r_infl_v[i] <= r_infl_v[i-1];
      end
    end

    // Number of reads issued but not yet landed.
    always_comb begin
      w_infl_cnt = '0;
      for (int i = 0; i < RD_LAT; i++) w_infl_cnt = w_infl_cnt + SW'(r_infl_v[i]);
    end

    assign w_cap = r_infl_v[RD_LAT-1];
  end else begin : g_comb
    // Combinational read: the word lands in the same cycle as the pop.
    assign w_infl_cnt = '0;
    assign w_cap      = rinc;
  end

  fifo_skid_buf #(.DW(DW), .DEPTH(DEPTH)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_cap),
    .i_data (rdata),
    .i_pop  (w_pop),
    .o_data (m_data),
    .o_occ  (w_occ)
  );

`ifdef FIFO_RD_STATS_EN
  // Saturating pop and downstream-stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (rinc && pop_cnt != '1) pop_cnt <= pop_cnt + CW'(1);
      if (m_valid && !m_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Four readers, with RD_LAT = 0..3, each fed by a small FIFO read-side model.
// Lane 3 uses CW=3, which makes its statistics counters saturate quickly.
module tb_fifo_stream_reader;

  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst, en;
  logic [NL-1:0] rinc, rempty, m_valid, m_ready, idle, force_empty;
  logic [15:0] rdata  [NL];
  logic [15:0] m_data [NL];
  logic [15:0] mem [NL][1024];
  int wr_cnt [NL];
  int exp_i [NL], issued [NL], got [NL];
  logic prev_stall [NL];
  logic [15:0] prev_data [NL];
  int checks = 0, errors = 0;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] pop_cnt [NL], stall_cnt [NL];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int CWL = (g == 3) ? 3 : 16;
    int head;
    logic [15:0] pipe [4];

    always @(posedge clk) begin
      if (rst) head <= 0;
      else if (rinc[g]) head <= head + 1;
    end
    assign rempty[g] = force_empty[g] || (head >= wr_cnt[g]);

    if (g == 0) begin : g_rd0
      assign rdata[g] = mem[g][head % 1024];
    end else begin : g_rdn
      always @(posedge clk) begin
        pipe[0] <= rinc[g] ? mem[g][head % 1024] : 16'hDEAD;
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
      assign rdata[g] = pipe[g-1];
    end

`ifdef FIFO_RD_STATS_EN
    logic [CWL-1:0] pc, sc;
    assign pop_cnt[g]   = 16'(pc);
    assign stall_cnt[g] = 16'(sc);
`endif

    fifo_stream_reader #(.DW(16), .RD_LAT(g), .CW(CWL)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .rempty  (rempty[g]),
      .rinc    (rinc[g]),
      .rdata   (rdata[g]),
      .m_valid (m_valid[g]),
      .m_ready (m_ready[g]),
      .m_data  (m_data[g]),
      .idle    (idle[g])
`ifdef FIFO_RD_STATS_EN
      ,
      .pop_cnt   (pc),
      .stall_cnt (sc)
`endif
    );
  end

  typedef struct {
    logic r1, v1; logic [15:0] d1; logic i1;
    logic r2, v2; logic [15:0] d2; logic i2;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Scoreboard, occupancy bound and stream stability. This runs at the negedge.
  task automatic sample();
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("occupancy bound L%0d", l), 32'(issued[l] - got[l] <= l + 1), 1);
      if (prev_stall[l]) begin
        chk($sformatf("stable valid L%0d", l), m_valid[l], 1);
        chk($sformatf("stable data L%0d", l), m_data[l], prev_data[l]);
      end
      if (m_valid[l] && m_ready[l]) begin
        chk($sformatf("no extra word L%0d", l), 32'(exp_i[l] < wr_cnt[l]), 1);
        chk($sformatf("order L%0d #%0d", l, exp_i[l]), m_data[l], mem[l][exp_i[l] % 1024]);
        exp_i[l]++;
        got[l]++;
      end
      if (rinc[l]) issued[l]++;
      prev_stall[l] = m_valid[l] && !m_ready[l];
      prev_data[l]  = m_data[l];
    end
  endtask

  task automatic finish_cyc();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cyc();
  endtask

  task automatic clr_model();
    for (int l = 0; l < NL; l++) begin
      wr_cnt[l] = 0; exp_i[l] = 0; issued[l] = 0; got[l] = 0;
      prev_stall[l] = 1'b0; prev_data[l] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; m_ready = '0; force_empty = '0;
    repeat (2) @(posedge clk);
    #1;
    clr_model();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; m_ready = '0; force_empty = '0;
    clr_model();
    // rinc stays low under reset even though lane 1 has data.
    wr_cnt[1] = 4;
    @(negedge clk);
    chk("rinc gated by rst", rinc, 4'h0);
    @(posedge clk); @(posedge clk); #1;
    clr_model();
    rst = 1'b0;

    // Empty FIFO with en high: nothing moves.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("empty rinc", rinc, 4'h0);
      chk("empty m_valid", m_valid, 4'h0);
      chk("empty idle", idle, 4'hF);
      finish_cyc();
    end
`ifdef FIFO_RD_STATS_EN
    chk("pop_cnt reset", pop_cnt[1], 0);
`endif

    // Table: lane 1 streams 8 words with ready high; lane 2 takes 6 words while ready is held low.
    tbl[0]  = '{1,0,16'h0000,1, 1,0,16'h0000,1};
    tbl[1]  = '{1,0,16'h0000,0, 1,0,16'h0000,0};
    tbl[2]  = '{1,1,16'h0001,0, 1,0,16'h0000,0};
    tbl[3]  = '{1,1,16'h0002,0, 0,1,16'h0201,0};
    tbl[4]  = '{1,1,16'h0003,0, 0,1,16'h0201,0};
    tbl[5]  = '{1,1,16'h0004,0, 0,1,16'h0201,0};
    tbl[6]  = '{1,1,16'h0005,0, 0,1,16'h0201,0};
    tbl[7]  = '{1,1,16'h0006,0, 0,1,16'h0201,0};
    tbl[8]  = '{0,1,16'h0007,0, 0,1,16'h0201,0};
    tbl[9]  = '{0,1,16'h0008,0, 0,1,16'h0201,0};
    tbl[10] = '{0,0,16'h0000,1, 0,1,16'h0201,0};
    for (int i = 0; i < 8; i++) mem[1][i] = 16'(i + 1);
    for (int i = 0; i < 6; i++) mem[2][i] = 16'(16'h0201 + i);
    wr_cnt[1] = 8; wr_cnt[2] = 6;
    m_ready = 4'b0010;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("t%0d L1 rinc", i), rinc[1], tbl[i].r1);
      chk($sformatf("t%0d L1 valid", i), m_valid[1], tbl[i].v1);
      if (tbl[i].v1) chk($sformatf("t%0d L1 data", i), m_data[1], tbl[i].d1);
      chk($sformatf("t%0d L1 idle", i), idle[1], tbl[i].i1);
      chk($sformatf("t%0d L2 rinc", i), rinc[2], tbl[i].r2);
      chk($sformatf("t%0d L2 valid", i), m_valid[2], tbl[i].v2);
      if (tbl[i].v2) chk($sformatf("t%0d L2 data", i), m_data[2], tbl[i].d2);
      chk($sformatf("t%0d L2 idle", i), idle[2], tbl[i].i2);
      finish_cyc();
    end
    m_ready = 4'b0110;
    for (int c = 0; c < 40 && !(got[2] == 6 && idle[2]); c++) cycle();
    chk("L2 delivered", got[2], 6);
    chk("L1 delivered", got[1], 8);
    chk("idle after drain", idle, 4'hF);

    // Random ready, random empty bubbles, and a trickle-filled FIFO on every lane.
    do_reset();
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < 1000; i++) mem[l][i] = 16'(l * 4096 + i);
    for (int c = 0; c < 20000 && (got[0] < 1000 || got[1] < 1000 || got[2] < 1000 || got[3] < 1000); c++) begin
      for (int l = 0; l < NL; l++) begin
        m_ready[l]     = 1'($urandom % 2);
        force_empty[l] = ($urandom % 4) == 0;
        if (wr_cnt[l] < 1000 && ($urandom % 3) != 0) wr_cnt[l]++;
      end
      cycle();
    end
    force_empty = '0; m_ready = '1;
    repeat (8) cycle();
    for (int l = 0; l < NL; l++) chk($sformatf("random delivered L%0d", l), got[l], 1000);
    chk("random idle", idle, 4'hF);

    // Reset on lane 3 with 2 words in flight and 1 buffered.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) mem[3][i] = 16'(16'h0301 + i);
    wr_cnt[3] = 4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("L3 pre-reset rinc", rinc[3], 1);
      finish_cyc();
    end
    en = 1'b0;
    cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("L3 busy before reset", {m_valid[3], idle[3]}, 2'b10);
    chk("L3 rinc during rst", rinc[3], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clr_model();
    @(negedge clk);
    chk("L3 valid after rst", m_valid[3], 0);
    chk("L3 idle after rst", idle[3], 1);
    chk("L3 rinc after rst", rinc[3], 0);
    finish_cyc();
    for (int i = 0; i < 4; i++) mem[3][i] = 16'(16'h3301 + i);
    wr_cnt[3] = 4; en = 1'b1; m_ready = '1;
    for (int c = 0; c < 30 && !(got[3] == 4 && idle[3]); c++) cycle();
    repeat (4) cycle();
    chk("L3 fresh words only", got[3], 4);
    chk("L3 quiet after drain", m_valid[3], 0);

`ifdef FIFO_RD_STATS_EN
    // Lane 1: 5 pops with 4 stall cycles. Lane 3: 10 pops into a 3-bit counter.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mem[1][i] = 16'(16'h1100 + i);
      mem[3][i] = 16'(16'h3300 + i);
    end
    wr_cnt[1] = 5; wr_cnt[3] = 10;
    m_ready = 4'b1000;
    repeat (6) cycle();
    m_ready = 4'b1010;
    for (int c = 0; c < 60 && !(got[1] == 5 && got[3] == 10 && idle[1] && idle[3]); c++) cycle();
    chk("L1 stats delivered", got[1], 5);
    chk("pop_cnt", pop_cnt[1], 5);
    chk("stall_cnt", stall_cnt[1], 4);
    chk("pop_cnt saturates", pop_cnt[3], 7);
    chk("stall_cnt no stalls", stall_cnt[3], 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the async FIFO, in the FIFO read-clock domain.
- Watches rempty, issues rinc pops, and captures rdata after a fixed read latency.
- Presents the captured words downstream as a valid/ready stream.
- Absorbs in-flight words in an internal skid buffer, so it sustains 1 word/cycle while m_ready stays high and never drops a word under backpressure.

Parameters:
- DW, 16, data word width; must match the FIFO dw.
- RD_LAT, 1, cycles from rinc asserted to rdata valid; legal range 0..3. 0 means combinational read.
- CW, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  read-domain clock; same clock as the FIFO read side.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enables issuing new pops; words already in flight always complete.
- rempty  in  1  FIFO empty flag, read domain.
- rinc  out  1  FIFO pop request; combinational.
- rdata  in  DW  FIFO read data, valid RD_LAT cycles after rinc.
- m_valid  out  1  downstream word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DW  downstream word.
- idle  out  1  high when nothing is in flight and the buffer is empty.

Behaviour:
- Constant DEPTH = RD_LAT+1. Skid buffer: circular, DEPTH entries, rd_ptr/wr_ptr, occupancy counter occ (0..DEPTH).
- In-flight tracker: shift register infl_v[RD_LAT] of rinc history; infl_cnt = popcount(infl_v).
- Reset (rst high at a clk edge): infl_v=0, occ=0, pointers=0, so m_valid=0, rinc=0, idle=1.
  - m_data is don't-care while m_valid=0; it is driven as buf[rd_ptr].
- pop_out = m_valid & m_ready.
- rinc = en & !rempty & !rst & (infl_cnt + occ - pop_out < DEPTH).
  - Combinational path m_ready -> rinc is intentional; it allows back-to-back throughput.
- Landing: cap = infl_v[RD_LAT-1] when RD_LAT>0, else cap = rinc.
  - When cap=1: buf[wr_ptr] <= rdata, wr_ptr increments modulo DEPTH.
- occ_next = occ + cap - pop_out. Simultaneous landing and pop is allowed, and occ is unchanged.
- Invariant infl_cnt + occ <= DEPTH. Overflow is impossible by construction; the bench asserts it.
- Output: m_valid = (occ != 0). m_data = buf[rd_ptr]. rd_ptr increments modulo DEPTH on pop_out.
- Stream rule: once m_valid=1, m_valid and m_data stay stable until accepted.
- Latency: rinc at cycle t gives m_valid=1 with that word at cycle t+RD_LAT+1.
  - Exception: RD_LAT=0 registers through the buffer, so the word appears at t+1.
- Throughput: 1 word/cycle when m_ready=1 and the FIFO stays non-empty.
- Backpressure: m_ready=0 stops new rinc once infl_cnt+occ reaches DEPTH. Landing words are buffered, never lost.
- en deassert: no new rinc; in-flight words still land and drain.
- rempty rising while reads are in flight: no new rinc. In-flight words are valid and delivered.
- idle = (infl_cnt == 0) & (occ == 0).
- Wrap-around: all pointers are modulo DEPTH. Handle DEPTH non-power-of-2 (e.g. RD_LAT=2) with explicit compare-and-clear.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO read-side reset must be asserted together with rst.
- Word order is strictly FIFO order.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- With the macro, extra ports are added:
  - pop_cnt out CW: counts rinc cycles.
  - stall_cnt out CW: counts cycles with m_valid & !m_ready.
  - Both counters saturate at all-ones and reset to 0 on rst.
- Without the macro, these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - DW/aw default localparams.
  - localparam function depth_of(rd_lat) returning rd_lat+1.
  - typedef word_t logic [DW-1:0].
- One natural sub-module: fifo_skid_buf, the DEPTH-entry circular buffer with push/pop/occ. Reuse it elsewhere.

Test Plan:
- Reset then rempty=1, en=1 -> rinc=0, m_valid=0, idle=1 for 10 cycles.
- RD_LAT=1, preload 8 words 0x0001..0x0008, m_ready=1:
  - rinc high 8 consecutive cycles.
  - m_valid high 8 consecutive cycles starting 2 cycles after the first rinc.
  - Data in order; then idle=1.
- RD_LAT=2, 6 words, m_ready held 0:
  - exactly 3 rincs, then rinc=0 and m_valid=1 with m_data=word0 held stable.
  - Release m_ready -> remaining 3 popped, all 6 delivered in order.
- Random m_ready (50%) and random rempty, 1000 words, RD_LAT in {0,1,3}:
  - scoreboard matches order, no loss or duplication.
  - infl_cnt+occ <= DEPTH assertion never fires.
- Assert rst while 2 words are in flight and 1 is buffered -> next cycle m_valid=0, idle=1, rinc=0; no stale word after reset release.
- With FIFO_RD_STATS_EN, 5 pops and 4 stall cycles -> pop_cnt=5, stall_cnt=4.
  - Force CW=3 and 10 pops -> pop_cnt saturates at 7.
